// File: rtl/chrono48_stop_ctrl.sv
// chrono48_stop_ctrl: UART command/readout, 4x12-bit stop capture, PWM DAC.
// Define STOP_SYNC_EN for a 2-flop synchronizer on each stop input.
module chrono48_stop_ctrl #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int CNT_W = 12,
  parameter int DAC_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] dev_addr,
  input  logic       rx_uc,
  output logic       tx_uc,
  input  logic       start_clk_sync,
  input  logic [3:0] stop_pulses,
  input  logic       teststop,
  output logic       cmd_reset,
  output logic       cmd_rst_dac,
  output logic       cmd_inc_dac,
  output logic       cmd_rst_test,
  output logic       cmd_dev_sel,
  output logic       DACout
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DAC_W-1:0] LVL_MAX = '1;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  rx_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic rx_valid, rx_valid_n;
  logic rx_s1, rx_s2, rx_d, rx_fall;

  tx_state_t tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic tx_req;
  logic [7:0] tx_data, rd_byte;

  logic d_reset, d_rst_dac, d_inc, d_test;
  logic d_start, d_sel, d_read;

  logic start_q, start_evt, clr;
  logic [CNT_W-1:0] coarse;
  logic [3:0][CNT_W-1:0] cap;
  logic [4*CNT_W-1:0] res;
  logic [3:0] armed, stop_raw, stop_edge;

  logic [DAC_W-1:0] dac_lvl, pwm_cnt;

  // two-flop RX synchronizer plus one delay for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_uc;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;

  // RX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_valid <= rx_valid_n;
    end
  end

  // RX FSM: half-bit start recheck, centre sampling
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_valid_n = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_state_n = RX_IDLE;
          rx_valid_n = rx_s2;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // command classification of the received byte
  always_comb begin
    d_reset   = 1'b0;
    d_rst_dac = 1'b0;
    d_inc     = 1'b0;
    d_test    = 1'b0;
    d_start   = 1'b0;
    d_sel     = 1'b0;
    d_read    = 1'b0;
    unique case (1'b1)
      (rx_sh == 8'h41): d_reset = 1'b1;
      (rx_sh == 8'h42): d_rst_dac = 1'b1;
      (rx_sh == 8'h43): d_inc = 1'b1;
      (rx_sh == 8'h45): d_test = 1'b1;
      (rx_sh == 8'h46): d_start = 1'b1;
      (rx_sh[7:3] == 5'b11000): d_sel = 1'b1;
      (rx_sh[7:3] == 5'b10000 && rx_sh[2:0] < 3'd6):
        d_read = 1'b1;
      default: ;
    endcase
  end

  assign res = cap;

  // readout byte mux over the 48-bit result
  always_comb begin
    rd_byte = '0;
    case (rx_sh[2:0])
      3'd0: rd_byte = res[7:0];
      3'd1: rd_byte = res[15:8];
      3'd2: rd_byte = res[23:16];
      3'd3: rd_byte = res[31:24];
      3'd4: rd_byte = res[39:32];
      3'd5: rd_byte = res[47:40];
      default: rd_byte = '0;
    endcase
  end

  // registered decode: strobes, select, DAC level, TX request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reset    <= 1'b0;
      cmd_rst_dac  <= 1'b0;
      cmd_inc_dac  <= 1'b0;
      cmd_rst_test <= 1'b0;
      cmd_dev_sel  <= 1'b0;
      tx_req       <= 1'b0;
      tx_data      <= '0;
      dac_lvl      <= '0;
    end else begin
      cmd_reset    <= rx_valid & d_reset;
      cmd_rst_dac  <= rx_valid & d_rst_dac;
      cmd_inc_dac  <= rx_valid & d_inc;
      cmd_rst_test <= rx_valid & d_test;
      tx_req       <= rx_valid & d_read & cmd_dev_sel;
      tx_data      <= rd_byte;
      if (rx_valid & d_reset) cmd_dev_sel <= 1'b0;
      else if (rx_valid & d_sel)
        cmd_dev_sel <= (rx_sh[2:0] == dev_addr);
      if (rx_valid & d_rst_dac) dac_lvl <= '0;
      else if (rx_valid & d_inc && dac_lvl != LVL_MAX)
        dac_lvl <= dac_lvl + DAC_W'(1);
    end
  end

  // start edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else start_q <= start_clk_sync;
  end

  assign start_evt = (start_clk_sync & ~start_q) | (rx_valid & d_start);
  assign clr = rx_valid & d_reset;
  assign stop_raw = stop_pulses | {4{teststop}};

`ifdef STOP_SYNC_EN
  logic [3:0] stop_s1, stop_s2, stop_d;

  // two-flop stop synchronizer plus edge delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_s1 <= '0;
      stop_s2 <= '0;
      stop_d  <= '0;
    end else begin
      stop_s1 <= stop_raw;
      stop_s2 <= stop_s1;
      stop_d  <= stop_s2;
    end
  end

  assign stop_edge = stop_s2 & ~stop_d;
`else
  logic [3:0] stop_s, stop_d;

  // single stop register plus edge delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_s <= '0;
      stop_d <= '0;
    end else begin
      stop_s <= stop_raw;
      stop_d <= stop_s;
    end
  end

  assign stop_edge = stop_s & ~stop_d;
`endif

  // saturating coarse counter restarted by start events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coarse <= '0;
    else if (start_evt) coarse <= '0;
    else if (coarse != CNT_MAX) coarse <= coarse + CNT_W'(1);
  end

  // captures track the counter while armed, freeze on stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap   <= '0;
      armed <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (start_evt) begin
          cap[i]   <= '0;
          armed[i] <= 1'b1;
        end else if (clr) begin
          cap[i]   <= '0;
          armed[i] <= 1'b0;
        end else if (armed[i]) begin
          cap[i] <= coarse;
          if (stop_edge[i]) armed[i] <= 1'b0;
        end
      end
    end
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
    end
  end

  // TX FSM: accepts requests only when idle
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_uc      = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_req) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_sh_n    = tx_data;
        end
      end
      TX_START: begin
        tx_uc = 1'b0;
        if (tx_cnt == BIT_END) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        tx_uc = tx_sh[0];
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else tx_bit_n = tx_bit + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_END) tx_state_n = TX_IDLE;
        else tx_cnt_n = tx_cnt + CW'(1);
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // free-running PWM with registered compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      DACout  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DAC_W'(1);
      DACout  <= (pwm_cnt < dac_lvl);
    end
  end

endmodule

// File: tb/tb_chrono48_stop_ctrl.sv
// tb_chrono48_stop_ctrl: UART-driven scoreboard bench for chrono48_stop_ctrl.
// Uses a short bit time so the whole command set fits a short run.
module tb_chrono48_stop_ctrl;

  localparam int CPB = 10;
`ifdef STOP_SYNC_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dev_addr = 3'd6;
  logic rx_uc = 1'b1;
  logic start_clk_sync = 1'b0;
  logic [3:0] stop_pulses = 4'h0;
  logic teststop = 1'b0;
  logic tx_uc, cmd_reset, cmd_rst_dac, cmd_inc_dac;
  logic cmd_rst_test, cmd_dev_sel, DACout;

  int n_vec = 0;
  int n_err = 0;
  int n_frames = 0;
  int n_rst = 0, n_rdac = 0, n_inc = 0, n_tst = 0;
  bit mon_busy = 1'b0;
  logic [7:0] sb[$];

  chrono48_stop_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dev_addr(dev_addr),
    .rx_uc(rx_uc),
    .tx_uc(tx_uc),
    .start_clk_sync(start_clk_sync),
    .stop_pulses(stop_pulses),
    .teststop(teststop),
    .cmd_reset(cmd_reset),
    .cmd_rst_dac(cmd_rst_dac),
    .cmd_inc_dac(cmd_inc_dac),
    .cmd_rst_test(cmd_rst_test),
    .cmd_dev_sel(cmd_dev_sel),
    .DACout(DACout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // strobe high-cycle counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_rst  += 32'(cmd_reset);
      n_rdac += 32'(cmd_rst_dac);
      n_inc  += 32'(cmd_inc_dac);
      n_tst  += 32'(cmd_rst_test);
    end
  end

  // TX frame receiver: pops the scoreboard per frame
  initial begin
    logic [7:0] b;
    b = '0;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge tx_uc);
      mon_busy = 1'b1;
      n_frames++;
      repeat (CPB / 2) @(negedge clk);
      chk("tx_start_bit", 48'(tx_uc), 48'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_uc;
      end
      repeat (CPB) @(negedge clk);
      chk("tx_stop_bit", 48'(tx_uc), 48'd1);
      chk("tx_expected", 48'(sb.size() > 0), 48'd1);
      if (sb.size() > 0) chk("tx_byte", 48'(b), 48'(sb.pop_front()));
      mon_busy = 1'b0;
    end
  end

  task automatic uart_send(input logic [7:0] b);
    rx_uc = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_uc = b[i];
      tick(CPB);
    end
    rx_uc = 1'b1;
    tick(3 * CPB);
  endtask

  task automatic send_bc(input logic [7:0] b, input int er,
                         input int ed, input int ei, input int et);
    n_rst = 0;
    n_rdac = 0;
    n_inc = 0;
    n_tst = 0;
    uart_send(b);
    chk($sformatf("cmd_reset_%02h", b), 48'(n_rst), 48'(er));
    chk($sformatf("cmd_rst_dac_%02h", b), 48'(n_rdac), 48'(ed));
    chk($sformatf("cmd_inc_dac_%02h", b), 48'(n_inc), 48'(ei));
    chk($sformatf("cmd_rst_test_%02h", b), 48'(n_tst), 48'(et));
  endtask

  task automatic duty(output int h);
    h = 0;
    repeat (256) begin
      @(negedge clk);
      h += 32'(DACout);
    end
  endtask

  task automatic wait_tx();
    int t = 0;
    while ((sb.size() != 0 || mon_busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("tx_wait", 48'(t < 1000), 48'd1);
    if (t >= 1000) sb.delete();
  endtask

  task automatic read_all(input logic [47:0] r);
    for (int n = 0; n < 6; n++) begin
      sb.push_back(r[8*n +: 8]);
      uart_send(8'h80 | 8'(n));
      wait_tx();
    end
  endtask

  task automatic no_tx(input string tag, input logic [7:0] b);
    int f;
    f = n_frames;
    uart_send(b);
    tick(15 * CPB);
    chk(tag, 48'(n_frames), 48'(f));
  endtask

  task automatic pulse_start();
    start_clk_sync = 1'b1;
    tick(1);
    start_clk_sync = 1'b0;
  endtask

  initial begin
    int h;
    tick(3);
    chk("rst_tx_uc", 48'(tx_uc), 48'd1);
    chk("rst_cmd_reset", 48'(cmd_reset), 48'd0);
    chk("rst_cmd_rst_dac", 48'(cmd_rst_dac), 48'd0);
    chk("rst_cmd_inc_dac", 48'(cmd_inc_dac), 48'd0);
    chk("rst_cmd_rst_test", 48'(cmd_rst_test), 48'd0);
    chk("rst_dev_sel", 48'(cmd_dev_sel), 48'd0);
    chk("rst_dacout", 48'(DACout), 48'd0);
    rst_n = 1'b1;
    tick(3);
    duty(h);
    chk("duty_reset", 48'(h), 48'd0);

    send_bc(8'h41, 1, 0, 0, 0);
    send_bc(8'h42, 0, 1, 0, 0);
    send_bc(8'h43, 0, 0, 1, 0);
    duty(h);
    chk("duty_lvl1", 48'(h), 48'd1);
    send_bc(8'h45, 0, 0, 0, 1);

    uart_send(8'hC6);
    chk("sel_c6", 48'(cmd_dev_sel), 48'd1);
    uart_send(8'hC5);
    chk("sel_c5", 48'(cmd_dev_sel), 48'd0);
    uart_send(8'hC6);
    chk("sel_c6_again", 48'(cmd_dev_sel), 48'd1);
    uart_send(8'h41);
    chk("sel_after_41", 48'(cmd_dev_sel), 48'd0);

    pulse_start();
    tick(99);
    stop_pulses = 4'hF;
    tick(2);
    stop_pulses = 4'h0;
    uart_send(8'hC6);
    read_all({4{12'(100 + LAT)}});

    no_tx("no_tx_read86", 8'h86);
    uart_send(8'hC5);
    no_tx("no_tx_deselected", 8'h80);

    pulse_start();
    tick(19);
    stop_pulses = 4'h1;
    tick(2);
    stop_pulses = 4'h0;
    tick(18);
    stop_pulses = 4'h2;
    tick(2);
    stop_pulses = 4'h0;
    tick(18);
    stop_pulses = 4'h4;
    tick(2);
    stop_pulses = 4'h0;
    tick(18);
    teststop = 1'b1;
    tick(2);
    teststop = 1'b0;
    tick(8);
    stop_pulses = 4'h1;
    tick(2);
    stop_pulses = 4'h0;
    uart_send(8'hC6);
    read_all({12'(80 + LAT), 12'(60 + LAT),
              12'(40 + LAT), 12'(20 + LAT)});

    uart_send(8'h46);
    tick(4200);
    read_all({4{12'hFFF}});

    uart_send(8'h41);
    uart_send(8'hC6);
    read_all(48'h0);

    repeat (300) uart_send(8'h43);
    duty(h);
    chk("duty_sat", 48'(h), 48'd255);
    send_bc(8'h42, 0, 1, 0, 0);
    duty(h);
    chk("duty_zero", 48'(h), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
